// File: rtl/restoring_divider_8bit.sv
// Unsigned 8-bit restoring divider, one quotient bit per clock, with
// valid/ready handshakes on the operand and result channels. Contains the
// ripple-carry adder used for the trial subtraction, followed by the top.

module ripple_carry_adder_8bit (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       Cin,
    output logic [7:0] Sum,
    output logic       Cout
);

    logic [8:0] carry;

    assign carry[0] = Cin;

    genvar i;
    generate
        for (i = 0; i < 8; i++) begin : g_fa
            assign Sum[i]     = A[i] ^ B[i] ^ carry[i];
            assign carry[i+1] = (A[i] & B[i]) | (A[i] & carry[i]) | (B[i] & carry[i]);
        end
    endgenerate

    assign Cout = carry[8];

endmodule

module restoring_divider_8bit (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] Dividend,
    input  logic [7:0] Divisor,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] Quotient,
    output logic [7:0] Remainder,
    output logic       DivByZero
);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] q_q, q_d;
    logic [7:0] d_q, d_d;
    // Stored remainder is 8 bits: after any iteration the 9th bit is always 0
    // (a successful subtract writes {0, Sum}; a restore only happens when R'[8] = 0).
    logic [7:0] r_q, r_d;
    logic [2:0] cnt_q, cnt_d;
    logic       dbz_q, dbz_d;
    logic       ready_q;

    logic       accept;
    logic [8:0] r_sh;
    logic [7:0] q_sh;
    logic [7:0] sub_sum;
    logic       sub_cout;
    logic       sub_ok;

    assign accept = in_valid && ready_q && (state_q == StIdle);

    // Shift {R, Q} left by one.
    assign r_sh = {r_q, q_q[7]};
    assign q_sh = {q_q[6:0], 1'b0};

    ripple_carry_adder_8bit u_sub (
        .A    (r_sh[7:0]),
        .B    (~d_q),
        .Cin  (1'b1),
        .Sum  (sub_sum),
        .Cout (sub_cout)
    );

    assign sub_ok = r_sh[8] | sub_cout;

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        d_d     = d_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    d_d     = Divisor;
                    state_d = StCalc;
                    if (Divisor == 8'd0) begin
                        // Result is loaded now; one pass through CALC with the
                        // counter at its last value gives the 1-cycle latency.
                        q_d   = 8'hFF;
                        r_d   = Dividend;
                        dbz_d = 1'b1;
                        cnt_d = 3'd7;
                    end else begin
                        q_d   = Dividend;
                        r_d   = 8'd0;
                        dbz_d = 1'b0;
                        cnt_d = 3'd0;
                    end
                end
            end
            StCalc: begin
                if (!dbz_q) begin
                    q_d = {q_sh[7:1], sub_ok};
                    r_d = sub_ok ? sub_sum : r_sh[7:0];
                end
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            q_q     <= 8'd0;
            d_q     <= 8'd0;
            r_q     <= 8'd0;
            cnt_q   <= 3'd0;
            dbz_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            d_q     <= d_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
            // Registered copy of "state is IDLE" so in_ready stays low during reset.
            ready_q <= (state_d == StIdle);
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = (state_q == StDone);
    assign Quotient  = q_q;
    assign Remainder = r_q;
    assign DivByZero = dbz_q;

endmodule

// File: tb/tb_restoring_divider_8bit.sv
// Self-checking bench for restoring_divider_8bit: directed table, hand-written
// backpressure and reset sequences, and a randomized sweep against a model.

module tb_restoring_divider_8bit;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] Dividend;
    logic [7:0] Divisor;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] Quotient;
    logic [7:0] Remainder;
    logic       DivByZero;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    restoring_divider_8bit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .DivByZero (DivByZero)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       z;
        int         lat;
        int         stall;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called and returns at a negedge. Runs one full transaction.
    task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] eq, input logic [7:0] er, input logic ez,
                          input int elat, input int stall);
        int lat;
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            step();
            guard++;
        end
        check({name, "/in_ready_idle"}, in_ready, 1);
        Dividend  = a;
        Divisor   = b;
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        step();  // accept edge
        in_valid = 1'b0;
        Dividend = 8'($urandom);
        Divisor  = 8'($urandom);
        check({name, "/in_ready_busy"}, in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        check({name, "/latency"}, lat, elat);
        for (int s = 0; s < stall; s++) begin
            check({name, "/stall_q"}, Quotient, eq);
            check({name, "/stall_r"}, Remainder, er);
            check({name, "/stall_valid"}, out_valid, 1);
            check({name, "/stall_in_ready"}, in_ready, 0);
            step();
        end
        out_ready = 1'b1;
        check({name, "/q"}, Quotient, eq);
        check({name, "/r"}, Remainder, er);
        check({name, "/dbz"}, DivByZero, ez);
        step();  // handshake edge
        check({name, "/valid_drop"}, out_valid, 0);
        check({name, "/in_ready_after"}, in_ready, 1);
    endtask

    initial begin
        int lat;
        logic [7:0] ra, rb, mq, mr;
        logic       mz;
        int         ml;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        Dividend  = 8'd0;
        Divisor   = 8'd0;

        tbl[0] = '{8'd200, 8'd7,   8'd28,  8'd4,   1'b0, 8, 0};
        tbl[1] = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 8, 0};
        tbl[2] = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 8, 0};
        tbl[3] = '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0, 8, 0};
        tbl[4] = '{8'd0,   8'd3,   8'd0,   8'd0,   1'b0, 8, 0};
        tbl[5] = '{8'd128, 8'd128, 8'd1,   8'd0,   1'b0, 8, 0};
        tbl[6] = '{8'd100, 8'd0,   8'hFF,  8'd100, 1'b1, 1, 0};
        tbl[7] = '{8'd9,   8'd3,   8'd3,   8'd0,   1'b0, 8, 0};
        tbl[8] = '{8'd200, 8'd7,   8'd28,  8'd4,   1'b0, 8, 3};
        tbl[9] = '{8'd37,  8'd0,   8'hFF,  8'd37,  1'b1, 1, 2};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst/in_ready", in_ready, 0);
        check("rst/out_valid", out_valid, 0);
        check("rst/q", Quotient, 0);
        check("rst/r", Remainder, 0);
        check("rst/dbz", DivByZero, 0);
        rst = 1'b0;
        step();
        check("rst/in_ready_after", in_ready, 1);
        check("rst/out_valid_after", out_valid, 0);

        // Directed table
        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r,
                   tbl[i].z, tbl[i].lat, tbl[i].stall);
        end

        // Backpressure with in_valid held high and new operands pending
        Dividend  = 8'd200;
        Divisor   = 8'd7;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        step();
        Dividend = 8'd50;
        Divisor  = 8'd5;
        lat = 0;
        while (!out_valid && lat < 20) begin
            check("bp/in_ready_calc", in_ready, 0);
            step();
            lat++;
        end
        check("bp/latency", lat, 8);
        repeat (5) begin
            check("bp/q", Quotient, 28);
            check("bp/r", Remainder, 4);
            check("bp/valid", out_valid, 1);
            check("bp/in_ready_done", in_ready, 0);
            step();
        end
        out_ready = 1'b1;
        step();  // handshake
        check("bp/valid_drop", out_valid, 0);
        check("bp/in_ready_after", in_ready, 1);
        step();  // pending 50/5 accepted here
        in_valid = 1'b0;
        check("bp/in_ready_2nd", in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        check("bp/latency_2nd", lat, 8);
        check("bp/q_2nd", Quotient, 10);
        check("bp/r_2nd", Remainder, 0);
        step();
        check("bp/valid_drop_2nd", out_valid, 0);

        // Reset in the 4th CALC cycle
        Dividend  = 8'd200;
        Divisor   = 8'd7;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        check("mid_rst/valid", out_valid, 0);
        check("mid_rst/q", Quotient, 0);
        check("mid_rst/r", Remainder, 0);
        check("mid_rst/dbz", DivByZero, 0);
        check("mid_rst/in_ready", in_ready, 0);
        rst = 1'b0;
        step();
        check("mid_rst/in_ready_after", in_ready, 1);
        repeat (10) begin
            check("mid_rst/no_stale_result", out_valid, 0);
            step();
        end
        run_op("mid_rst/50_6", 8'd50, 8'd6, 8'd8, 8'd2, 1'b0, 8, 0);

        // Randomized sweep against the arithmetic model
        for (int n = 0; n < 2000; n++) begin
            ra = 8'($urandom_range(0, 255));
            rb = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            if (rb == 8'd0) begin
                mq = 8'hFF;
                mr = ra;
                mz = 1'b1;
                ml = 1;
            end else begin
                mq = ra / rb;
                mr = ra % rb;
                mz = 1'b0;
                ml = 8;
            end
            run_op($sformatf("rand%0d_%0d_%0d", n, ra, rb), ra, rb, mq, mr, mz, ml,
                   ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
